ram_8x4_bist: RTL



---
 rtl/ram_8x4_bist.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/ram_8x4_bist.sv
// ram_8x4_bist
//
// Purpose:
//   Built-in self-test initiator for an 8x4 single-port RAM.
//   A test run starts on a start pulse. The run writes a deterministic
//   pattern to all eight locations, then reads every location back.
//   Each read is compared against the value that was written. The run
//   ends with a one-cycle done pulse, a pass flag, a saturating mismatch
//   count and the address of the first mismatch.
//
// Configuration macro:
//   BIST_INVERT_PASS_EN - when defined, a second pass runs after the first.
//                         The second pass uses the bitwise-inverted
//                         pattern, so every cell bit is exercised at both
//                         0 and 1. When undefined, only the true-pattern
//                         pass runs and no pass index register exists.
//
// Parameters:
//   READ_LAT  - cycles from presenting a read address to valid ram_rdata
//               (1 or 2)
//   PATTERN   - XOR seed for the data pattern
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   run request, sampled only while idle
//   ram_en     out  RAM write enable (1 = write, 0 = read)
//   ram_addr   out  RAM address
//   ram_wdata  out  RAM write data
//   ram_rdata  in   RAM read data
//   busy       out  high while a run is in progress
//   done       out  one-cycle pulse at the end of a run
//   pass       out  1 when the last run saw no mismatch
//   err_count  out  mismatch count of the run, saturating at 15
//   fail_addr  out  address of the first mismatch of the run, 0 if none

module ram_8x4_bist #(
    parameter int unsigned READ_LAT = 1,
    parameter logic [3:0]  PATTERN  = 4'b0101
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       ram_en,
    output logic [2:0] ram_addr,
    output logic [3:0] ram_wdata,
    input  logic [3:0] ram_rdata,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] fail_addr
);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        DONE
    } state_t;

    // The read phase issues eight addresses, then drains READ_LAT cycles.
    localparam logic [3:0] LAST_RD_STEP = 4'(7 + READ_LAT);

    state_t     state_q;
    logic [3:0] step_q;
    logic       ramEn_q;
    logic [2:0] ramAddr_q;
    logic [3:0] ramWdata_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [3:0] errCount_q;
    logic [2:0] failAddr_q;

    logic       pipeVld_q  [READ_LAT];
    logic [3:0] pipeExp_q  [READ_LAT];
    logic [2:0] pipeAddr_q [READ_LAT];

    logic       invert;
    logic       issue_d;
    logic [3:0] issueExp_d;
    logic       mismatch_d;

`ifdef BIST_INVERT_PASS_EN
    logic       passIdx_q;
    assign invert = passIdx_q;
`else
    assign invert = 1'b0;
`endif

    function automatic logic [3:0] patternOf(input logic [2:0] a, input logic inv);
        return ({1'b0, a} ^ PATTERN) ^ {4{inv}};
    endfunction

    // A read is issued in every read-phase cycle that still has an address
    // to present; drain cycles issue nothing.
    assign issue_d    = (state_q == RD) && (step_q < 4'd8);
    assign issueExp_d = patternOf(ramAddr_q, invert);
    assign mismatch_d = pipeVld_q[READ_LAT-1] && (ram_rdata != pipeExp_q[READ_LAT-1]);

    // Expected value and address travel READ_LAT stages alongside the RAM
    // read, so the last stage lines up with the returned data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < READ_LAT; i++) begin
                pipeVld_q[i]  <= 1'b0;
                pipeExp_q[i]  <= 4'h0;
                pipeAddr_q[i] <= 3'd0;
            end
        end else begin
            pipeVld_q[0]  <= issue_d;
            pipeExp_q[0]  <= issueExp_d;
            pipeAddr_q[0] <= ramAddr_q;
            for (int i = 1; i < READ_LAT; i++) begin
                pipeVld_q[i]  <= pipeVld_q[i-1];
                pipeExp_q[i]  <= pipeExp_q[i-1];
                pipeAddr_q[i] <= pipeAddr_q[i-1];
            end
        end
    end

    // Sequencer plus result bookkeeping. The final compare lands on the
    // edge that leaves the read phase, so the result is complete when the
    // DONE state publishes pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            step_q     <= 4'd0;
            ramEn_q    <= 1'b0;
            ramAddr_q  <= 3'd0;
            ramWdata_q <= 4'h0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            errCount_q <= 4'd0;
            failAddr_q <= 3'd0;
`ifdef BIST_INVERT_PASS_EN
            passIdx_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;

            if (mismatch_d) begin
                if (errCount_q != 4'd15) begin
                    errCount_q <= errCount_q + 4'd1;
                end
                if (errCount_q == 4'd0) begin
                    failAddr_q <= pipeAddr_q[READ_LAT-1];
                end
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= WR;
                        step_q     <= 4'd0;
                        busy_q     <= 1'b1;
                        pass_q     <= 1'b0;
                        errCount_q <= 4'd0;
                        failAddr_q <= 3'd0;
                        ramEn_q    <= 1'b1;
                        ramAddr_q  <= 3'd0;
                        ramWdata_q <= patternOf(3'd0, 1'b0);
`ifdef BIST_INVERT_PASS_EN
                        passIdx_q  <= 1'b0;
`endif
                    end
                end
                WR: begin
                    if (step_q == 4'd7) begin
                        state_q    <= RD;
                        step_q     <= 4'd0;
                        ramEn_q    <= 1'b0;
                        ramAddr_q  <= 3'd0;
                        ramWdata_q <= 4'h0;
                    end else begin
                        step_q     <= step_q + 4'd1;
                        ramAddr_q  <= step_q[2:0] + 3'd1;
                        ramWdata_q <= patternOf(step_q[2:0] + 3'd1, invert);
                    end
                end
                RD: begin
                    if (step_q == LAST_RD_STEP) begin
`ifdef BIST_INVERT_PASS_EN
                        if (!passIdx_q) begin
                            state_q    <= WR;
                            step_q     <= 4'd0;
                            passIdx_q  <= 1'b1;
                            ramEn_q    <= 1'b1;
                            ramAddr_q  <= 3'd0;
                            ramWdata_q <= patternOf(3'd0, 1'b1);
                        end else begin
                            state_q    <= DONE;
                            ramAddr_q  <= 3'd0;
                        end
`else
                        state_q   <= DONE;
                        ramAddr_q <= 3'd0;
`endif
                    end else begin
                        step_q <= step_q + 4'd1;
                        // Address holds at 7 through the drain cycles.
                        if (step_q < 4'd7) begin
                            ramAddr_q <= step_q[2:0] + 3'd1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    pass_q  <= (errCount_q == 4'd0);
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ram_en    = ramEn_q;
    assign ram_addr  = ramAddr_q;
    assign ram_wdata = ramWdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = errCount_q;
    assign fail_addr = failAddr_q;

endmodule
